// File: rtl/apb2axi_id_pool.sv
// Shared AXI ID allocator for the APB2AXI write and read builders, with per-direction outstanding limits.
// Define APB2AXI_ID_POOL_BYPASS_EN to let a legal release be re-granted in the same cycle.
module apb2axi_id_pool #(
    parameter int AXI_ID_W   = 4,
    parameter int NUM_IDS    = 16,
    parameter int MAX_WR_OUT = 8,
    parameter int MAX_RD_OUT = 8,
    localparam int CNT_W     = $clog2(NUM_IDS + 1)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                wr_req_valid,
    output logic                wr_req_ready,
    output logic [AXI_ID_W-1:0] wr_req_id,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    output logic [AXI_ID_W-1:0] rd_req_id,
    input  logic                wr_rel_valid,
    input  logic [AXI_ID_W-1:0] wr_rel_id,
    input  logic                rd_rel_valid,
    input  logic [AXI_ID_W-1:0] rd_rel_id,
    output logic [CNT_W-1:0]    wr_outstanding,
    output logic [CNT_W-1:0]    rd_outstanding,
    output logic                idle,
    output logic                rel_err,
    input  logic                clr_err
);

    localparam int ID_SPACE = 2 ** AXI_ID_W;

    // IDs at or above NUM_IDS are never granted, so their in_use bit stays 0
    // and any release naming them falls out as illegal.
    logic [ID_SPACE-1:0] in_use;
    logic [ID_SPACE-1:0] owner;
    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic                rr;
    logic                rel_err_r;
    logic                idle_r;

    logic [ID_SPACE-1:0] in_use_d;
    logic [ID_SPACE-1:0] owner_d;
    logic [CNT_W-1:0]    wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_d;
    logic                rr_d;
    logic                rel_err_d;

    logic                wr_rel_legal;
    logic                rd_rel_legal;
    logic                rel_illegal;
    logic [ID_SPACE-1:0] rel_clr;
    logic [ID_SPACE-1:0] avail;
    logic [CNT_W-1:0]    wr_cnt_eff;
    logic [CNT_W-1:0]    rd_cnt_eff;

    logic                first_found;
    logic                second_found;
    logic [AXI_ID_W-1:0] first_id;
    logic [AXI_ID_W-1:0] second_id;

    logic                wr_elig;
    logic                rd_elig;
    logic                wr_rdy;
    logic                rd_rdy;
    logic                wr_grant;
    logic                rd_grant;
    logic                contention;

    assign wr_rel_legal = wr_rel_valid & in_use[wr_rel_id] & ~owner[wr_rel_id];
    assign rd_rel_legal = rd_rel_valid & in_use[rd_rel_id] &  owner[rd_rel_id];
    assign rel_illegal  = (wr_rel_valid & ~wr_rel_legal) | (rd_rel_valid & ~rd_rel_legal);

    always_comb begin
        rel_clr = '0;
        if (wr_rel_legal) rel_clr[wr_rel_id] = 1'b1;
        if (rd_rel_legal) rel_clr[rd_rel_id] = 1'b1;
    end

`ifdef APB2AXI_ID_POOL_BYPASS_EN
    // A legal release frees both the ID and its direction's slot this cycle.
    assign avail      = ~in_use | rel_clr;
    assign wr_cnt_eff = wr_cnt - CNT_W'(wr_rel_legal);
    assign rd_cnt_eff = rd_cnt - CNT_W'(rd_rel_legal);
`else
    assign avail      = ~in_use;
    assign wr_cnt_eff = wr_cnt;
    assign rd_cnt_eff = rd_cnt;
`endif

    // Lowest and second-lowest free IDs within the pool.
    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_id     = '0;
        second_id    = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (avail[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_id    = AXI_ID_W'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_id    = AXI_ID_W'(i);
                end
            end
        end
    end

    assign wr_elig = first_found && (wr_cnt_eff < CNT_W'(MAX_WR_OUT));
    assign rd_elig = first_found && (rd_cnt_eff < CNT_W'(MAX_RD_OUT));

    // Each ready looks only at state and the other side's valid, never its own.
    always_comb begin
        wr_rdy = 1'b0;
        rd_rdy = 1'b0;
        if (aresetn) begin
            if (wr_elig && rd_elig && !second_found) begin
                wr_rdy = !rd_req_valid || !rr;
                rd_rdy = !wr_req_valid ||  rr;
            end else begin
                wr_rdy = wr_elig;
                rd_rdy = rd_elig;
            end
        end
    end

    assign wr_grant   = wr_req_valid & wr_rdy;
    assign rd_grant   = rd_req_valid & rd_rdy;
    assign contention = aresetn & wr_req_valid & rd_req_valid & wr_elig & rd_elig & ~second_found;

    assign wr_req_ready = wr_rdy;
    assign rd_req_ready = rd_rdy;
    assign wr_req_id    = first_id;
    assign rd_req_id    = (wr_grant && second_found) ? second_id : first_id;

    // Releases clear first so a bypassed same-ID regrant ends up set.
    always_comb begin
        in_use_d = in_use & ~rel_clr;
        owner_d  = owner;
        if (wr_grant) begin
            in_use_d[wr_req_id] = 1'b1;
            owner_d[wr_req_id]  = 1'b0;
        end
        if (rd_grant) begin
            in_use_d[rd_req_id] = 1'b1;
            owner_d[rd_req_id]  = 1'b1;
        end
    end

    assign wr_cnt_d  = wr_cnt + CNT_W'(wr_grant) - CNT_W'(wr_rel_legal);
    assign rd_cnt_d  = rd_cnt + CNT_W'(rd_grant) - CNT_W'(rd_rel_legal);
    assign rr_d      = rr ^ contention;
    assign rel_err_d = rel_illegal ? 1'b1 : (clr_err ? 1'b0 : rel_err_r);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_use    <= '0;
            owner     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rr        <= 1'b0;
            rel_err_r <= 1'b0;
            idle_r    <= 1'b1;
        end else begin
            in_use    <= in_use_d;
            owner     <= owner_d;
            wr_cnt    <= wr_cnt_d;
            rd_cnt    <= rd_cnt_d;
            rr        <= rr_d;
            rel_err_r <= rel_err_d;
            idle_r    <= ~|in_use_d;
        end
    end

    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;
    assign idle           = idle_r;
    assign rel_err        = rel_err_r;

endmodule

// File: tb/tb_apb2axi_id_pool.sv
// Directed bench for apb2axi_id_pool: a pool-level model checked every cycle plus hand-computed expectations.
module tb_apb2axi_id_pool;

    localparam int W    = 4;
    localparam int NUM  = 16;
    localparam int MAXW = 15;
    localparam int MAXR = 2;
    localparam int CW   = $clog2(NUM + 1);
`ifdef APB2AXI_ID_POOL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          aclk;
    logic          aresetn;
    logic          wr_req_valid, wr_req_ready;
    logic [W-1:0]  wr_req_id;
    logic          rd_req_valid, rd_req_ready;
    logic [W-1:0]  rd_req_id;
    logic          wr_rel_valid, rd_rel_valid;
    logic [W-1:0]  wr_rel_id, rd_rel_id;
    logic [CW-1:0] wr_outstanding, rd_outstanding;
    logic          idle, rel_err, clr_err;

    apb2axi_id_pool #(
        .AXI_ID_W  (W),
        .NUM_IDS   (NUM),
        .MAX_WR_OUT(MAXW),
        .MAX_RD_OUT(MAXR)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_id     (wr_req_id),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_id     (rd_req_id),
        .wr_rel_valid  (wr_rel_valid),
        .wr_rel_id     (wr_rel_id),
        .rd_rel_valid  (rd_rel_valid),
        .rd_rel_id     (rd_rel_id),
        .wr_outstanding(wr_outstanding),
        .rd_outstanding(rd_outstanding),
        .idle          (idle),
        .rel_err       (rel_err),
        .clr_err       (clr_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Pool model: which IDs are held and by whom; occupancy is counted from that.
    bit m_use[NUM];
    bit m_own[NUM];
    bit m_rr  = 1'b0;
    bit m_err = 1'b0;
    int fq[$];
    int wc, rc, wce, rce, ewid, erid;
    bit wl, rl, we, re, ewr, erd, ewg;

    function automatic bit legal(input bit v, input logic [W-1:0] id, input bit side);
        return v && (int'(id) < NUM) && m_use[id] && (m_own[id] == side);
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM; i++) begin
                m_use[i] = 1'b0;
                m_own[i] = 1'b0;
            end
            m_rr  = 1'b0;
            m_err = 1'b0;
        end
        wc = 0;
        rc = 0;
        for (int i = 0; i < NUM; i++)
            if (m_use[i]) begin
                if (m_own[i]) rc++;
                else wc++;
            end
        chk("m_wr_outstanding", int'(wr_outstanding), wc);
        chk("m_rd_outstanding", int'(rd_outstanding), rc);
        chk("m_idle", int'(idle), int'((wc + rc) == 0));
        chk("m_rel_err", int'(rel_err), int'(m_err));
        if (!aresetn) begin
            chk("m_rst_wr_ready", int'(wr_req_ready), 0);
            chk("m_rst_rd_ready", int'(rd_req_ready), 0);
            chk("m_rst_wr_id", int'(wr_req_id), 0);
            chk("m_rst_rd_id", int'(rd_req_id), 0);
        end else begin
            wl = legal(wr_rel_valid, wr_rel_id, 1'b0);
            rl = legal(rd_rel_valid, rd_rel_id, 1'b1);
            fq.delete();
            for (int i = 0; i < NUM; i++)
                if (!m_use[i] || (BYP && ((wl && int'(wr_rel_id) == i) || (rl && int'(rd_rel_id) == i))))
                    fq.push_back(i);
            wce = wc - ((BYP && wl) ? 1 : 0);
            rce = rc - ((BYP && rl) ? 1 : 0);
            we  = (fq.size() > 0) && (wce < MAXW);
            re  = (fq.size() > 0) && (rce < MAXR);
            if (we && re && fq.size() == 1) begin
                ewr = !rd_req_valid || !m_rr;
                erd = !wr_req_valid || m_rr;
            end else begin
                ewr = we;
                erd = re;
            end
            ewg  = wr_req_valid && ewr;
            ewid = (fq.size() > 0) ? fq[0] : 0;
            erid = (ewg && fq.size() > 1) ? fq[1] : ewid;
            chk("m_wr_ready", int'(wr_req_ready), int'(ewr));
            chk("m_rd_ready", int'(rd_req_ready), int'(erd));
            if (ewr) chk("m_wr_id", int'(wr_req_id), ewid);
            if (erd) chk("m_rd_id", int'(rd_req_id), erid);
            if (wl) m_use[wr_rel_id] = 1'b0;
            if (rl) m_use[rd_rel_id] = 1'b0;
            if (ewg) begin
                m_use[ewid] = 1'b1;
                m_own[ewid] = 1'b0;
            end
            if (rd_req_valid && erd) begin
                m_use[erid] = 1'b1;
                m_own[erid] = 1'b1;
            end
            if (we && re && fq.size() == 1 && wr_req_valid && rd_req_valid) m_rr = !m_rr;
            if ((wr_rel_valid && !wl) || (rd_rel_valid && !rl)) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic quiet();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        wr_rel_valid = 1'b0;
        rd_rel_valid = 1'b0;
        clr_err      = 1'b0;
    endtask

    initial begin
        aresetn   = 1'b0;
        wr_rel_id = '0;
        rd_rel_id = '0;
        quiet();
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_idle", int'(idle), 1);
        chk("rst_wr_ready", int'(wr_req_ready), 0);
        chk("rst_rd_ready", int'(rd_req_ready), 0);
        chk("rst_wr_id", int'(wr_req_id), 0);
        chk("rst_wr_out", int'(wr_outstanding), 0);
        chk("rst_rel_err", int'(rel_err), 0);
        aresetn = 1'b1;

        // Three back-to-back write grants: IDs 0, 1, 2.
        wr_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wr_first_rdy", int'(wr_req_ready), 1);
            chk("wr_first_id", int'(wr_req_id), i);
            tick();
        end
        wr_req_valid = 1'b0;
        #1;
        chk("wr_out_3", int'(wr_outstanding), 3);
        chk("not_idle", int'(idle), 0);

        // Fill to 15 IDs in use (14 write, 1 read), then contend for ID 15.
        wr_req_valid = 1'b1;
        repeat (11) tick();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1;
        #1;
        chk("rd_id_14", int'(rd_req_id), 14);
        tick();
        wr_req_valid = 1'b1;
        #1;
        chk("cont_wr_rdy", int'(wr_req_ready), 1);
        chk("cont_wr_id", int'(wr_req_id), 15);
        chk("cont_rd_rdy", int'(rd_req_ready), 0);
        tick();
        quiet();

        // Free ID 3; with both requesting, read now wins it.
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd3;
        tick();
        quiet();
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        #1;
        chk("rr_rd_rdy", int'(rd_req_ready), 1);
        chk("rr_rd_id", int'(rd_req_id), 3);
        chk("rr_wr_rdy", int'(wr_req_ready), 0);
        tick();
        quiet();

        // Read limit: ID 0 free but two reads outstanding.
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd0;
        tick();
        quiet();
        rd_req_valid = 1'b1;
        #1;
        chk("rd_limit_stall", int'(rd_req_ready), 0);
        tick();
        rd_rel_valid = 1'b1;
        rd_rel_id    = 4'd14;
        #1;
`ifdef APB2AXI_ID_POOL_BYPASS_EN
        chk("rd_rel_same_rdy", int'(rd_req_ready), 1);
        chk("rd_rel_same_id", int'(rd_req_id), 0);
        tick();
        rd_rel_valid = 1'b0;
`else
        chk("rd_rel_same_rdy", int'(rd_req_ready), 0);
        tick();
        rd_rel_valid = 1'b0;
        #1;
        chk("rd_rel_next_rdy", int'(rd_req_ready), 1);
        chk("rd_rel_next_id", int'(rd_req_id), 0);
        tick();
`endif
        quiet();
        #1;
        chk("rd_out_2", int'(rd_outstanding), 2);

        // Fill the pool, then release ID 5 while write keeps requesting.
        wr_req_valid = 1'b1;
        #1;
        chk("fill_wr_id", int'(wr_req_id), 14);
        tick();
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd5;
        #1;
`ifdef APB2AXI_ID_POOL_BYPASS_EN
        chk("wr_rel_same_rdy", int'(wr_req_ready), 1);
        chk("wr_rel_same_id", int'(wr_req_id), 5);
        tick();
        wr_rel_valid = 1'b0;
`else
        chk("wr_rel_same_rdy", int'(wr_req_ready), 0);
        tick();
        wr_rel_valid = 1'b0;
        #1;
        chk("wr_rel_next_rdy", int'(wr_req_ready), 1);
        chk("wr_rel_next_id", int'(wr_req_id), 5);
        tick();
`endif
        quiet();
        #1;
        chk("wr_out_14", int'(wr_outstanding), 14);

        // Illegal releases: wrong owner, free ID, set beats clear.
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd3;
        tick();
        quiet();
        #1;
        chk("err_wrong_owner", int'(rel_err), 1);
        chk("err_rd_out_hold", int'(rd_outstanding), 2);
        chk("err_wr_out_hold", int'(wr_outstanding), 14);
        clr_err = 1'b1;
        tick();
        quiet();
        #1;
        chk("err_cleared", int'(rel_err), 0);
        rd_rel_valid = 1'b1;
        rd_rel_id    = 4'd3;
        tick();
        quiet();
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd3;
        clr_err      = 1'b1;
        tick();
        quiet();
        #1;
        chk("err_set_wins", int'(rel_err), 1);
        chk("err_free_rd_out", int'(rd_outstanding), 1);
        clr_err = 1'b1;
        tick();
        quiet();
        rd_rel_valid = 1'b1;
        rd_rel_id    = 4'd5;
        tick();
        quiet();
        #1;
        chk("err_rd_side", int'(rel_err), 1);
        clr_err = 1'b1;
        tick();
        quiet();

        // Grant ID 3 while releasing ID 7: write count holds.
        wr_req_valid = 1'b1;
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd7;
        #1;
        chk("grant_rel_id", int'(wr_req_id), 3);
        tick();
        quiet();
        #1;
        chk("grant_rel_hold", int'(wr_outstanding), 14);

        // Two or more free: write takes lowest, read the next.
        wr_rel_valid = 1'b1;
        wr_rel_id    = 4'd8;
        tick();
        wr_rel_id    = 4'd9;
        tick();
        quiet();
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        #1;
        chk("dual_wr_rdy", int'(wr_req_ready), 1);
        chk("dual_rd_rdy", int'(rd_req_ready), 1);
        chk("dual_wr_id", int'(wr_req_id), 7);
        chk("dual_rd_id", int'(rd_req_id), 8);
        tick();
        quiet();
        #1;
        chk("dual_wr_out", int'(wr_outstanding), 13);
        chk("dual_rd_out", int'(rd_outstanding), 2);

        // Asynchronous reset mid-operation.
        aresetn = 1'b0;
        #1;
        chk("mid_rst_idle", int'(idle), 1);
        chk("mid_rst_wr_out", int'(wr_outstanding), 0);
        chk("mid_rst_rd_out", int'(rd_outstanding), 0);
        chk("mid_rst_wr_rdy", int'(wr_req_ready), 0);
        tick();
        aresetn      = 1'b1;
        wr_req_valid = 1'b1;
        #1;
        chk("post_rst_rdy", int'(wr_req_ready), 1);
        chk("post_rst_id", int'(wr_req_id), 0);
        tick();
        quiet();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
